// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: IDLE/WAIT/RESP FSM with a
// programmable response latency, sub-word loads/stores and misalignment errors.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_addr,
  input  logic [2:0]  i_req_size,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [1:0]  o_dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            cap_wen;
  logic [AW+1:0]   cap_addr;
  logic [2:0]      cap_size;
  logic [31:0]     cap_wdata;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            take;
  logic            enter_resp;
  logic            use_in;
  logic            acc_wen;
  logic [AW+1:0]   acc_addr;
  logic [2:0]      acc_size;
  logic [31:0]     acc_wdata;
  logic [AW-1:0]   acc_idx;
  logic [1:0]      lane;
  logic [31:0]     mem_word;
  logic [31:0]     shifted;
  logic            acc_err;
  logic [31:0]     acc_rdata;
  logic [3:0]      be;
  logic [31:0]     wword;
  logic            unused_addr;

  // Upper address bits are deliberately dropped so accesses wrap.
  assign unused_addr = ^i_req_addr[31:AW+2];

  assign o_dbg_state = state;
  assign take        = (state == S_IDLE) && o_req_ready && i_req_valid;
  assign enter_resp  = (take && (LATENCY == 1)) || ((state == S_WAIT) && (cnt == 4'd0));

  // With LATENCY=1 the access happens on the accepting edge, so the live
  // request feeds the datapath while in IDLE; otherwise the captured copy does.
  assign use_in    = (state == S_IDLE);
  assign acc_wen   = use_in ? i_req_wen : cap_wen;
  assign acc_addr  = use_in ? i_req_addr[AW+1:0] : cap_addr;
  assign acc_size  = use_in ? i_req_size : cap_size;
  assign acc_wdata = use_in ? i_req_wdata : cap_wdata;
  assign acc_idx   = acc_addr[AW+1:2];
  assign lane      = acc_addr[1:0];
  assign mem_word  = mem[acc_idx];
  assign shifted   = mem_word >> {lane, 3'b000};

  always_comb begin
    acc_err   = 1'b0;
    acc_rdata = 32'd0;
    be        = 4'd0;
    wword     = 32'd0;
    case (acc_size)
      3'b000: begin
        be        = 4'b0001 << lane;
        wword     = {4{acc_wdata[7:0]}};
        acc_rdata = {{24{shifted[7]}}, shifted[7:0]};
      end
      3'b001: begin
        acc_err   = lane[0];
        be        = 4'b0011 << lane;
        wword     = {2{acc_wdata[15:0]}};
        acc_rdata = {{16{shifted[15]}}, shifted[15:0]};
      end
      3'b010: begin
        acc_err   = (lane != 2'b00);
        be        = 4'b1111;
        wword     = acc_wdata;
        acc_rdata = mem_word;
      end
      3'b100: begin
        acc_err   = acc_wen;
        acc_rdata = {24'd0, shifted[7:0]};
      end
      3'b101: begin
        acc_err   = acc_wen | lane[0];
        acc_rdata = {16'd0, shifted[15:0]};
      end
      default: acc_err = 1'b1;
    endcase
    if (acc_err || acc_wen) acc_rdata = 32'd0;
  end

  // Array is never reset; a reset edge also suppresses a pending store.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && enter_resp && acc_wen && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[acc_idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  // Handshakes: a request transfers on an edge with i_req_valid && o_req_ready;
  // a response transfers on an edge with o_rsp_valid && i_rsp_ready, and the
  // response fields stay frozen until then.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      o_req_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= 32'd0;
      o_rsp_err   <= 1'b0;
      cap_wen     <= 1'b0;
      cap_addr    <= '0;
      cap_size    <= 3'd0;
      cap_wdata   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            cap_wen     <= i_req_wen;
            cap_addr    <= i_req_addr[AW+1:0];
            cap_size    <= i_req_size;
            cap_wdata   <= i_req_wdata;
            o_req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state       <= S_RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_rdata <= acc_rdata;
              o_rsp_err   <= acc_err;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end else begin
            o_req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state       <= S_RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= acc_rdata;
            o_rsp_err   <= acc_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            state       <= S_IDLE;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 32'd0;
            o_rsp_err   <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          o_req_ready <= 1'b0;
          o_rsp_valid <= 1'b0;
          o_rsp_rdata <= 32'd0;
          o_rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance and a LATENCY=1 instance,
// directed requests with a per-instance expected queue checked by a monitor.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wen   [2];
  logic [31:0] req_addr  [2];
  logic [2:0]  req_size  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [1:0]  dbg_state [2];

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  int checks;
  int failures;
  int lat_of [2];

  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010,
                         SZ_BU = 3'b100, SZ_HU = 3'b101, SZ_BAD = 3'b011;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_wen(req_wen[0]), .i_req_addr(req_addr[0]),
    .i_req_size(req_size[0]), .i_req_wdata(req_wdata[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]),
    .o_dbg_state(dbg_state[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_wen(req_wen[1]), .i_req_addr(req_addr[1]),
    .i_req_size(req_size[1]), .i_req_wdata(req_wdata[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]),
    .o_dbg_state(dbg_state[1])
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  task automatic mon_check(input int s);
    logic [32:0] e;
    if (rsp_valid[s] && rsp_ready[s]) begin
      if ((s == 0 && exp_q0.size() == 0) || (s == 1 && exp_q1.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp dut%0d: got err=%0b rdata=0x%0h expected no response",
                 s, rsp_err[s], rsp_rdata[s]);
      end else begin
        e = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("rsp_rdata dut%0d", s), 64'(rsp_rdata[s]), 64'(e[31:0]));
        check($sformatf("rsp_err dut%0d", s), 64'(rsp_err[s]), 64'(e[32]));
      end
    end else if (!rsp_valid[s]) begin
      check($sformatf("idle_zero dut%0d", s), 64'({rsp_err[s], rsp_rdata[s]}), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    mon_check(0);
    mon_check(1);
  end

  // Driver: issues one request and walks it through its response handshake.
  task automatic do_req(input int s, input logic wen, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int stall);
    int n;
    int k;
    logic [31:0] held;
    if (s == 0) exp_q0.push_back({exp_err, exp_rd});
    else        exp_q1.push_back({exp_err, exp_rd});
    rsp_ready[s] = (stall == 0);
    req_wen[s]   = wen;
    req_addr[s]  = addr;
    req_size[s]  = size;
    req_wdata[s] = wdata;
    req_valid[s] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready[s]) break;
      @(posedge clk); #1;
      n++;
      if (n > 40) begin
        check("accept_timeout", 64'd0, 64'd1);
        req_valid[s] = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    if (stall == 0) req_valid[s] = 1'b0;
    k = 1;
    forever begin
      @(negedge clk);
      if (rsp_valid[s]) break;
      @(posedge clk); #1;
      k++;
      if (k > 40) begin
        check("rsp_timeout", 64'd0, 64'd1);
        req_valid[s] = 1'b0;
        rsp_ready[s] = 1'b1;
        return;
      end
    end
    check($sformatf("latency dut%0d", s), 64'(k), 64'(lat_of[s]));
    if (stall > 0) begin
      held = rsp_rdata[s];
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check("stall_valid", 64'(rsp_valid[s]), 64'd1);
        check("stall_rdata", 64'(rsp_rdata[s]), 64'(held));
        check("stall_req_ready", 64'(req_ready[s]), 64'd0);
        @(posedge clk); #1;
      end
      rsp_ready[s] = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    lat_of[0] = 2;
    lat_of[1] = 1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_wen[s]   = 1'b0;
      req_addr[s]  = 32'd0;
      req_size[s]  = 3'd0;
      req_wdata[s] = 32'd0;
      rsp_ready[s] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(rsp_valid[0]), 64'd0);
    check("rst_state", 64'(dbg_state[0]), 64'd0);
    check("rst_req_ready", 64'(req_ready[0]), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", 64'(req_ready[0]), 64'd1);
    @(posedge clk); #1;

    // LATENCY=2: word store/load, byte merge, sign/zero extension
    do_req(0, 1'b1, 32'h10, SZ_W,  32'hDEADBEEF, 32'h0,        1'b0, 0);
    do_req(0, 1'b0, 32'h10, SZ_W,  32'h0,        32'hDEADBEEF, 1'b0, 0);
    do_req(0, 1'b1, 32'h11, SZ_B,  32'h000000AA, 32'h0,        1'b0, 0);
    do_req(0, 1'b0, 32'h10, SZ_W,  32'h0,        32'hDEADAAEF, 1'b0, 0);
    do_req(0, 1'b0, 32'h11, SZ_B,  32'h0,        32'hFFFFFFAA, 1'b0, 0);
    do_req(0, 1'b0, 32'h11, SZ_BU, 32'h0,        32'h000000AA, 1'b0, 0);
    do_req(0, 1'b0, 32'h12, SZ_H,  32'h0,        32'hFFFFDEAD, 1'b0, 0);
    do_req(0, 1'b0, 32'h12, SZ_HU, 32'h0,        32'h0000DEAD, 1'b0, 0);
    // Errors: misaligned half/word, illegal size codes; memory unchanged
    do_req(0, 1'b0, 32'h13, SZ_H,  32'h0,        32'h0,        1'b1, 0);
    do_req(0, 1'b1, 32'h12, SZ_W,  32'h11111111, 32'h0,        1'b1, 0);
    do_req(0, 1'b0, 32'h10, SZ_BAD, 32'h0,       32'h0,        1'b1, 0);
    do_req(0, 1'b1, 32'h10, SZ_BU, 32'h22222222, 32'h0,        1'b1, 0);
    do_req(0, 1'b0, 32'h10, SZ_W,  32'h0,        32'hDEADAAEF, 1'b0, 0);
    do_req(0, 1'b1, 32'h10, SZ_H,  32'hFFFF1234, 32'h0,        1'b0, 0);
    // Stalled response with the request held high, then the same request again
    do_req(0, 1'b0, 32'h10, SZ_W,  32'h0,        32'hDEAD1234, 1'b0, 5);
    do_req(0, 1'b0, 32'h10, SZ_W,  32'h0,        32'hDEAD1234, 1'b0, 0);

    // Reset during WAIT aborts a store
    do_req(0, 1'b1, 32'h20, SZ_W,  32'h12345678, 32'h0,        1'b0, 0);
    req_wen[0]   = 1'b1;
    req_addr[0]  = 32'h20;
    req_size[0]  = SZ_W;
    req_wdata[0] = 32'hCAFEF00D;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("abort_ready", 64'(req_ready[0]), 64'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_rsp", 64'(rsp_valid[0]), 64'd0);
    end
    @(posedge clk); #1;
    do_req(0, 1'b0, 32'h20, SZ_W,  32'h0,        32'h12345678, 1'b0, 0);

    // LATENCY=1 instance: address wrap modulo 4*DEPTH_WORDS
    do_req(1, 1'b1, 32'h1000, SZ_W, 32'hA5A55A5A, 32'h0,        1'b0, 0);
    do_req(1, 1'b0, 32'h0,    SZ_W, 32'h0,        32'hA5A55A5A, 1'b0, 0);
    do_req(1, 1'b1, 32'h2003, SZ_B, 32'h00000077, 32'h0,        1'b0, 0);
    do_req(1, 1'b0, 32'h0,    SZ_W, 32'h0,        32'h77A55A5A, 1'b0, 0);
    do_req(1, 1'b0, 32'h3,    SZ_B, 32'h0,        32'h00000077, 1'b0, 0);

    repeat (3) @(posedge clk);
    check("leftover_q0", 64'(exp_q0.size()), 64'd0);
    check("leftover_q1", 64'(exp_q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the storage array (power of two, at least 4).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the cycles from request acceptance to response valid (legal range 1..15).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port i_req_valid, input, 1 bit: the core presents a data-memory request.
REQ-006 SHALL have port o_req_ready, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port i_req_wen, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port i_req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port i_req_size, input, 3 bits: access size coded as RV32I funct3.
REQ-010 SHALL have port i_req_wdata, input, 32 bits: store data, right-aligned (byte/half in low bits).
REQ-011 SHALL have port o_rsp_valid, output, 1 bit: a response is available.
REQ-012 SHALL have port i_rsp_ready, input, 1 bit: the core accepts the response.
REQ-013 SHALL have port o_rsp_rdata, output, 32 bits: load data, already extended.
REQ-014 SHALL have port o_rsp_err, output, 1 bit: the request was illegal or misaligned.

Function
REQ-015 SHALL implement states IDLE, WAIT and RESP; o_req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a clock edge where i_req_valid and o_req_ready are both 1, capturing wen, addr, size and wdata.
REQ-017 SHALL move from IDLE to WAIT when LATENCY > 1 (loading the counter with LATENCY-2), and directly to RESP when LATENCY = 1.
REQ-018 SHALL, in WAIT, decrement the counter each cycle and move to RESP on the edge where the counter is 0.
REQ-019 SHALL perform the array access on the edge entering RESP, so o_rsp_valid first rises exactly LATENCY cycles after the accepting edge.
REQ-020 SHALL hold o_rsp_valid, o_rsp_rdata and o_rsp_err stable in RESP until i_rsp_ready = 1, then return to IDLE on that edge.
REQ-021 SHALL ignore i_req_valid outside IDLE; there is no request queueing and at most one transaction is outstanding.
REQ-022 SHALL form the word index from i_req_addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-023 SHALL treat these load sizes as legal: 000 LB (sign-extend), 001 LH (sign-extend), 010 LW, 100 LBU (zero-extend), 101 LHU (zero-extend).
REQ-024 SHALL treat these store sizes as legal: 000 SB, 001 SH, 010 SW.
REQ-025 SHALL place the selected byte or half from addr[1:0] into bits [7:0] or [15:0] of a load result before extension.
REQ-026 SHALL, on a store, write only the addressed bytes, placed from wdata[7:0] or wdata[15:0] at lane addr[1:0]; all other bytes are preserved.
REQ-027 SHALL set o_rsp_err = 1 for any illegal size code, a half access with addr[0] = 1, or a word access with addr[1:0] != 00.
REQ-028 SHALL, on an error, leave memory unmodified and return o_rsp_rdata = 0.
REQ-029 SHALL return o_rsp_rdata = 0 and o_rsp_err = 0 for a legal store; a store still requires the response handshake.
REQ-030 SHALL drive o_rsp_rdata and o_rsp_err to 0 whenever o_rsp_valid = 0.

Reset
REQ-031 SHALL, on an edge with i_rst_n = 0, enter IDLE, clear the counter, and set o_rsp_valid = 0, o_rsp_rdata = 0 and o_rsp_err = 0.
REQ-032 SHALL treat reset in WAIT or RESP as an abort: the pending transaction is discarded, and a pending store SHALL NOT be written.
REQ-033 SHALL NOT reset the array contents.
REQ-034 SHALL hold o_req_ready = 1 from the first edge after reset release that finds the block in IDLE.

Verification
REQ-035 SHALL be verified, with LATENCY = 2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> o_rsp_valid two cycles after each accept; rdata 0xDEADBEEF, err 0.
REQ-036 SHALL be verified: SB addr 0x11 data 0x000000AA over word 0xDEADBEEF, then LW 0x10 -> 0xDEADAAEF; LB 0x11 -> 0xFFFFFFAA; LBU 0x11 -> 0x000000AA.
REQ-037 SHALL be verified: LH 0x13 and SW 0x12 -> err = 1, rdata 0, memory unchanged; size 011 -> err = 1.
REQ-038 SHALL be verified: response stalled by i_rsp_ready = 0 for 5 cycles with i_req_valid held high -> rdata stable, o_req_ready = 0, second request accepted only after the handshake.
REQ-039 SHALL be verified: i_rst_n low for one cycle during WAIT of SW 0x20 -> no response; a later LW 0x20 returns the prior contents.
REQ-040 SHALL be verified: with LATENCY = 1 and DEPTH_WORDS = 1024, SW to 0x1000 then LW 0x0 -> data aliases (wrap), and response arrives one cycle after accept.
